field_ast_packetizer: RTL

//  Upstream neighbour of the deinterlacer. Takes a raw interlaced pixel stream with field markers.

---
 rtl/video_ast_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 48 ++++
 rtl/field_ast_packetizer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/video_ast_pkg.sv
// video_ast_pkg: shared constants, the packetizer FSM state type and the
// control-packet nibble helper for the field Avalon-ST packetizer.
//   AST_TYPE_*    : packet type nibble carried by the first beat of a packet
//   INTERLACE_F*  : interlace nibble sent as the last control beat
//   ctrl_nibble() : nibble for control beat k (0..9) of a field
package video_ast_pkg;

  localparam logic [3:0] AST_TYPE_CTRL  = 4'hF;
  localparam logic [3:0] AST_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] INTERLACE_F0   = 4'b1000;
  localparam logic [3:0] INTERLACE_F1   = 4'b1100;
  localparam int         CTRL_BEATS     = 10;

  typedef enum logic [1:0] {IDLE, CTRL, VHDR, VPIX} pkt_state_t;

  // Beat k of the control packet: type, width nibbles MSB first,
  // field-height nibbles MSB first, then the interlace nibble.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0]  k,
                                             input logic [15:0] width,
                                             input logic [15:0] height,
                                             input logic        field);
    logic [3:0] nib;
    nib = 4'h0;
    case (k)
      4'd0: nib = AST_TYPE_CTRL;
      4'd1: nib = width[15:12];
      4'd2: nib = width[11:8];
      4'd3: nib = width[7:4];
      4'd4: nib = width[3:0];
      4'd5: nib = height[15:12];
      4'd6: nib = height[11:8];
      4'd7: nib = height[7:4];
      4'd8: nib = height[3:0];
      4'd9: nib = field ? INTERLACE_F1 : INTERLACE_F0;
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO. The head word is always visible
// on rd_data while !empty; rd_en pops it.
//   clock, reset_n : clock, synchronous active-low reset (flushes pointers)
//   wr_en, wr_data : write request; ignored while full
//   rd_en, rd_data : pop request / head word; ignored while empty
//   full, empty    : status, derived from registered pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/field_ast_packetizer.sv
// field_ast_packetizer: turns a raw interlaced pixel stream with field
// markers into Avalon-ST video: per field a 10-beat control packet, then a
// video packet of exactly WIDTH*HEIGHT/2 pixels (padded or truncated).
//   clock, reset_n          : clock, synchronous active-low reset
//   vid_data/valid/sof/field: pixel source, no backpressure
//   dout_*                  : AST source, ready latency 0
//   err_overflow            : sticky, a pixel was dropped on a full FIFO
//   err_short_field         : sticky, a field was padded with zeros
module field_ast_packetizer
  import video_ast_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 2,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int WIDTH            = 720,
  parameter int HEIGHT           = 576,
  parameter int FIFO_DEPTH       = 1024
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0]  vid_data,
  input  logic                                         vid_valid,
  input  logic                                         vid_sof,
  input  logic                                         vid_field,
  output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0]  dout_data,
  input  logic                                         dout_ready,
  output logic                                         dout_valid,
  output logic                                         dout_startofpacket,
  output logic                                         dout_endofpacket,
  output logic                                         err_overflow,
  output logic                                         err_short_field
);

  localparam int DW          = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
  localparam int HALF_HEIGHT = HEIGHT / 2;
  localparam int FIELD_PX    = WIDTH * HALF_HEIGHT;
  localparam int PX_W        = $clog2(FIELD_PX + 1);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(FIELD_PX - 1);
  localparam logic [3:0]      K_LAST  = 4'(CTRL_BEATS - 1);

  // FIFO word = {sof, field, data}
  logic [DW+1:0] fifo_q;
  logic          fifo_full, fifo_empty, pop;
  logic          head_sof, head_field;
  logic [DW-1:0] head_data;

  assign head_sof   = fifo_q[DW+1];
  assign head_field = fifo_q[DW];
  assign head_data  = fifo_q[DW-1:0];

  sync_fifo #(.WIDTH(DW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (vid_valid),
    .wr_data ({vid_sof, vid_field, vid_data}),
    .rd_en   (pop),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  pkt_state_t      state, next_state;
  logic [3:0]      k_cnt;
  logic [PX_W-1:0] px_cnt;
  logic            field_q;

  // The output register takes a new beat whenever it is empty or its
  // current beat is being accepted; the FSM tracks the *next* beat to load.
  logic          can_load;
  logic          ld_valid, ld_sop, ld_eop, pad;
  logic [DW-1:0] ld_data;

  assign can_load = !dout_valid || dout_ready;

  function automatic logic [DW-1:0] nib_beat(input logic [3:0] nib);
    return {{(DW-4){1'b0}}, nib};
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!fifo_empty && head_sof && can_load) next_state = CTRL;
      CTRL: if (can_load && k_cnt == K_LAST)          next_state = VHDR;
      VHDR: if (can_load)                              next_state = VPIX;
      VPIX: if (ld_valid && px_cnt == PX_LAST)         next_state = IDLE;
      default:                                         next_state = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    pop      = 1'b0;
    pad      = 1'b0;
    ld_valid = 1'b0;
    ld_sop   = 1'b0;
    ld_eop   = 1'b0;
    ld_data  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (!head_sof) begin
            pop = 1'b1;                      // tail of an over-long field
          end else if (can_load) begin
            // SOF stays in the FIFO; it becomes pixel 0 of the video packet.
            ld_valid = 1'b1;
            ld_sop   = 1'b1;
            ld_data  = nib_beat(ctrl_nibble(4'd0, 16'(WIDTH), 16'(HALF_HEIGHT), head_field));
          end
        end
      end
      CTRL: begin
        if (can_load) begin
          ld_valid = 1'b1;
          ld_eop   = (k_cnt == K_LAST);
          ld_data  = nib_beat(ctrl_nibble(k_cnt, 16'(WIDTH), 16'(HALF_HEIGHT), field_q));
        end
      end
      VHDR: begin
        if (can_load) begin
          ld_valid = 1'b1;
          ld_sop   = 1'b1;
          ld_data  = nib_beat(AST_TYPE_VIDEO);
        end
      end
      VPIX: begin
        if (can_load && !fifo_empty) begin
          ld_valid = 1'b1;
          ld_eop   = (px_cnt == PX_LAST);
          if (head_sof && px_cnt != '0) begin
            pad = 1'b1;                      // next field arrived early
          end else begin
            pop     = 1'b1;
            ld_data = head_data;
          end
        end
      end
      default: ;
    endcase
  end

  // Counters and latched field
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      k_cnt   <= '0;
      px_cnt  <= '0;
      field_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (next_state == CTRL) begin
          k_cnt   <= 4'd1;
          field_q <= head_field;
        end
        CTRL: if (can_load) k_cnt <= k_cnt + 4'd1;
        VHDR: px_cnt <= '0;
        VPIX: if (ld_valid) px_cnt <= px_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Output register and sticky flags
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dout_valid         <= 1'b0;
      dout_data          <= '0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      err_overflow       <= 1'b0;
      err_short_field    <= 1'b0;
    end else begin
      if (can_load) begin
        dout_valid         <= ld_valid;
        dout_data          <= ld_data;
        dout_startofpacket <= ld_sop;
        dout_endofpacket   <= ld_eop;
      end
      if (vid_valid && fifo_full) err_overflow    <= 1'b1;
      if (pad)                    err_short_field <= 1'b1;
    end
  end

endmodule
